rv32_bus_seq: RTL and testbench

Memory-access sequencer between the RV32 core's execute/memory stage and the 6502-style 8-bit external bus. It takes one 32-bit load/store request at a time and turns it into 1, 2 or 4 consecutive little-endian byte cycles. It honours RDY stalls and the lock signal, then returns the assembled and extended load data or a fault. The core sees a simple valid/ready request port and a single-cycle response pulse.

---
 rtl/rv32_bus_pkg.sv | 31 +++
 rtl/rv32_load_ext.sv | 25 ++
 rtl/rv32_bus_seq.sv | 179 +++++++++++++++++
 tb/tb_rv32_bus_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_bus_pkg.sv
// Shared encodings and helpers for the RV32 8-bit bus sequencer.
package rv32_bus_pkg;

  localparam int ADDR_W_DEFAULT = 16;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  // Index of the final byte of an access (n-1); illegal size never reaches XFER.
  function automatic logic [1:0] size_last_idx(input logic [1:0] size);
    case (size)
      SZ_B:    return 2'd0;
      SZ_H:    return 2'd1;
      SZ_W:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/rv32_load_ext.sv
// Load data assembly: picks the low byte/half/word of the little-endian buffer
// and sign- or zero-extends it to 32 bits.
module rv32_load_ext
  import rv32_bus_pkg::*;
(
  input  logic [31:0] buf_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic sext;
  assign sext = !unsigned_i;

  always_comb begin
    data_o = 32'd0;
    case (size_i)
      SZ_B:    data_o = {{24{sext & buf_i[7]}}, buf_i[7:0]};
      SZ_H:    data_o = {{16{sext & buf_i[15]}}, buf_i[15:0]};
      SZ_W:    data_o = buf_i;
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv32_bus_seq.sv
// Splits one 32-bit load/store into 1/2/4 little-endian byte cycles on the 8-bit bus.
// Define RV32_MISALIGN_TRAP_EN to fault misaligned halves/words instead of running them.
module rv32_bus_seq
  import rv32_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              PH0IN,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_fault,
  output logic [31:0]       resp_rdata,
  input  logic              RDY,
  input  logic              rdy_writes,
  output logic [ADDR_W-1:0] A_o,
  output logic              RWn,
  output logic [7:0]        D_o,
  input  logic [7:0]        D_i,
  output logic              D_oe,
  output logic              MLn
);

  seq_state_e        state_q;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [1:0]        last_q;
  logic [1:0]        k_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;

  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_fault_q;
  logic [31:0]       resp_rdata_q;
  logic [ADDR_W-1:0] a_q;
  logic              rwn_q;
  logic [7:0]        d_o_q;
  logic              d_oe_q;
  logic              mln_q;

  logic [1:0]        last_d;
  logic [ADDR_W:0]   end_addr_d;
  logic              fault_d;
  logic              rdy_ok;
  logic [31:0]       buf_d;
  logic [31:0]       ext_data;

  always_comb begin
    last_d     = size_last_idx(req_size);
    end_addr_d = {1'b0, req_addr[ADDR_W-1:0]} + {{(ADDR_W-1){1'b0}}, last_d};
    fault_d    = 1'b0;
    if (req_size == SZ_X) fault_d = 1'b1;
    if ((req_addr >> ADDR_W) != 32'd0) fault_d = 1'b1;
    // Carry out of the address field means the access would wrap past the top.
    if (end_addr_d[ADDR_W]) fault_d = 1'b1;
`ifdef RV32_MISALIGN_TRAP_EN
    if ((req_size == SZ_H) && req_addr[0]) fault_d = 1'b1;
    if ((req_size == SZ_W) && (req_addr[1:0] != 2'b00)) fault_d = 1'b1;
`endif
  end

  assign rdy_ok = RDY || (we_q && !rdy_writes);

  always_comb begin
    buf_d = buf_q;
    buf_d[{k_q, 3'b000} +: 8] = D_i;
  end

  // Fed with the buffer including the byte captured this edge, so the final
  // load byte is already part of the response.
  rv32_load_ext u_load_ext (
    .buf_i      (buf_d),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  always_ff @(negedge PH0IN) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= SZ_B;
      last_q       <= 2'd0;
      k_q          <= 2'd0;
      wdata_q      <= 32'd0;
      buf_q        <= 32'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      a_q          <= '0;
      rwn_q        <= 1'b1;
      d_o_q        <= 8'd0;
      d_oe_q       <= 1'b0;
      mln_q        <= 1'b1;
    end else begin
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'd0;

      case (state_q)
        ST_IDLE: begin
          if (req_ready_q && req_valid) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            uns_q       <= req_unsigned;
            size_q      <= req_size;
            last_q      <= last_d;
            k_q         <= 2'd0;
            wdata_q     <= req_wdata;
            buf_q       <= 32'd0;
            if (fault_d) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
            end else begin
              state_q <= ST_XFER;
              a_q     <= req_addr[ADDR_W-1:0];
              rwn_q   <= !req_we;
              d_o_q   <= req_we ? sel_byte(req_wdata, 2'd0) : 8'd0;
              d_oe_q  <= req_we;
              mln_q   <= (last_d == 2'd0);
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        ST_XFER: begin
          if (rdy_ok) begin
            if (!we_q) buf_q <= buf_d;
            if (k_q == last_q) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= we_q ? 32'd0 : ext_data;
              rwn_q        <= 1'b1;
              d_o_q        <= 8'd0;
              d_oe_q       <= 1'b0;
              mln_q        <= 1'b1;
            end else begin
              k_q <= k_q + 2'd1;
              a_q <= a_q + {{(ADDR_W-1){1'b0}}, 1'b1};
              if (we_q) d_o_q <= sel_byte(wdata_q, k_q + 2'd1);
            end
          end
        end

        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;
  assign A_o        = a_q;
  assign RWn        = rwn_q;
  assign D_o        = d_o_q;
  assign D_oe       = d_oe_q;
  assign MLn        = mln_q;

endmodule

// File: tb/tb_rv32_bus_seq.sv
// Directed bench for rv32_bus_seq: drives accesses, models the 8-bit bus and
// checks bus cycles, latency span and response data against hand-computed values.
module tb_rv32_bus_seq;
  import rv32_bus_pkg::*;

  logic        PH0IN;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_fault;
  logic [31:0] resp_rdata;
  logic        RDY;
  logic        rdy_writes;
  logic [15:0] A_o;
  logic        RWn;
  logic [7:0]  D_o;
  logic [7:0]  D_i;
  logic        D_oe;
  logic        MLn;

  rv32_bus_seq #(.ADDR_W(16)) dut (
    .PH0IN        (PH0IN),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_fault   (resp_fault),
    .resp_rdata   (resp_rdata),
    .RDY          (RDY),
    .rdy_writes   (rdy_writes),
    .A_o          (A_o),
    .RWn          (RWn),
    .D_o          (D_o),
    .D_i          (D_i),
    .D_oe         (D_oe),
    .MLn          (MLn)
  );

  initial PH0IN = 1'b1;
  always #5 PH0IN = ~PH0IN;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Read-side bus model: four bytes starting at rd_base, everything else 0xEE.
  logic [15:0] rd_base;
  logic [7:0]  rd_bytes [0:3];

  task automatic set_rd(input logic [15:0] base, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
    rd_base     = base;
    rd_bytes[0] = b0;
    rd_bytes[1] = b1;
    rd_bytes[2] = b2;
    rd_bytes[3] = b3;
  endtask

  function automatic logic [7:0] bus_byte(input logic [15:0] a);
    logic [15:0] off;
    off = a - rd_base;
    if (off < 16'd4) return rd_bytes[off[1:0]];
    return 8'hEE;
  endfunction

  // Per-cycle log of bus outputs between accept and response.
  logic [15:0] a_log  [0:15];
  logic [7:0]  d_log  [0:15];
  logic        rw_log [0:15];
  logic        ml_log [0:15];
  logic        oe_log [0:15];
  int          log_n;
  logic        rw_at_resp;
  logic        oe_at_resp;

  task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input int stall0, input logic exp_fault, input logic [31:0] exp_rdata,
                           input int exp_span);
    int          c;
    int          stalls_left;
    int          got_lat;
    logic        done;
    logic        got_fault;
    logic [31:0] got_rdata;
    log_n      = 0;
    done       = 1'b0;
    got_lat    = -1;
    got_fault  = 1'b0;
    got_rdata  = 32'd0;
    rw_at_resp = 1'b0;
    oe_at_resp = 1'b0;
    stalls_left = stall0;
    @(posedge PH0IN);
    c = 0;
    while (!req_ready && c < 20) begin
      @(posedge PH0IN);
      c++;
    end
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge PH0IN);
    req_valid = 1'b0;
    c = 0;
    while (!done && c < 60) begin
      c++;
      if (resp_valid) begin
        got_lat    = c - 1;
        got_fault  = resp_fault;
        got_rdata  = resp_rdata;
        rw_at_resp = RWn;
        oe_at_resp = D_oe;
        done       = 1'b1;
      end else begin
        if (log_n < 16) begin
          a_log[log_n]  = A_o;
          d_log[log_n]  = D_o;
          rw_log[log_n] = RWn;
          ml_log[log_n] = MLn;
          oe_log[log_n] = D_oe;
        end
        log_n++;
        D_i = bus_byte(A_o);
        RDY = (stalls_left == 0);
        if (stalls_left > 0) stalls_left--;
        @(posedge PH0IN);
      end
    end
    RDY = 1'b1;
    check_eq({tag, "_resp_seen"}, 32'(done), 32'd1);
    check_eq({tag, "_fault"}, 32'(got_fault), 32'(exp_fault));
    check_eq({tag, "_rdata"}, got_rdata, exp_rdata);
    // Span counts edges from the accept edge through the edge that ends RESP.
    check_eq({tag, "_span"}, 32'(got_lat + 2), 32'(exp_span));
    @(posedge PH0IN);
    check_eq({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    $display("access %s: addr=%h we=%0d size=%0d span=%0d fault=%0d rdata=%h",
             tag, addr, we, size, got_lat + 2, got_fault, got_rdata);
  endtask

  logic seen_resp;

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = SZ_B;
    req_unsigned = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    RDY          = 1'b1;
    rdy_writes   = 1'b1;
    D_i          = 8'd0;
    set_rd(16'h0000, 8'h00, 8'h00, 8'h00, 8'h00);

    repeat (3) @(posedge PH0IN);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_fault", 32'(resp_fault), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);
    check_eq("rst_A", 32'(A_o), 32'd0);
    check_eq("rst_RWn", 32'(RWn), 32'd1);
    check_eq("rst_D_o", 32'(D_o), 32'd0);
    check_eq("rst_D_oe", 32'(D_oe), 32'd0);
    check_eq("rst_MLn", 32'(MLn), 32'd1);
    rst_n = 1'b1;
    @(posedge PH0IN);
    check_eq("rst_release_ready", 32'(req_ready), 32'd1);
    $display("reset: ready=%0d RWn=%0d MLn=%0d", req_ready, RWn, MLn);

    // Word load, no stalls.
    set_rd(16'h1234, 8'h78, 8'h56, 8'h34, 8'h12);
    do_access("lw", 1'b0, SZ_W, 1'b0, 32'h0000_1234, 32'd0, 0, 1'b0, 32'h1234_5678, 6);
    check_eq("lw_cycles", 32'(log_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("lw_A%0d", i), 32'(a_log[i]), 32'h1234 + 32'(i));
      check_eq($sformatf("lw_MLn%0d", i), 32'(ml_log[i]), 32'd0);
      check_eq($sformatf("lw_RWn%0d", i), 32'(rw_log[i]), 32'd1);
    end

    // Signed / unsigned byte and half loads.
    set_rd(16'h0200, 8'h80, 8'h11, 8'h22, 8'h33);
    do_access("lb", 1'b0, SZ_B, 1'b0, 32'h0000_0200, 32'd0, 0, 1'b0, 32'hFFFF_FF80, 3);
    check_eq("lb_MLn", 32'(ml_log[0]), 32'd1);
    do_access("lbu", 1'b0, SZ_B, 1'b1, 32'h0000_0200, 32'd0, 0, 1'b0, 32'h0000_0080, 3);
    set_rd(16'h0300, 8'h34, 8'hF2, 8'h00, 8'h00);
    do_access("lh", 1'b0, SZ_H, 1'b0, 32'h0000_0300, 32'd0, 0, 1'b0, 32'hFFFF_F234, 4);
    do_access("lhu", 1'b0, SZ_H, 1'b1, 32'h0000_0300, 32'd0, 0, 1'b0, 32'h0000_F234, 4);

    // Half store, RDY low for two cycles on byte 0.
    rdy_writes = 1'b1;
    do_access("sh_stall", 1'b1, SZ_H, 1'b0, 32'h0000_0010, 32'h0000_12AB, 2, 1'b0, 32'd0, 6);
    check_eq("sh_stall_cycles", 32'(log_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("sh_stall_D%0d", i), 32'(d_log[i]), (i < 3) ? 32'hAB : 32'h12);
      check_eq($sformatf("sh_stall_A%0d", i), 32'(a_log[i]), (i < 3) ? 32'h10 : 32'h11);
      check_eq($sformatf("sh_stall_oe%0d", i), 32'(oe_log[i]), 32'd1);
      check_eq($sformatf("sh_stall_RWn%0d", i), 32'(rw_log[i]), 32'd0);
      check_eq($sformatf("sh_stall_MLn%0d", i), 32'(ml_log[i]), 32'd0);
    end
    rdy_writes = 1'b0;
    do_access("sh_nostall", 1'b1, SZ_H, 1'b0, 32'h0000_0010, 32'h0000_12AB, 2, 1'b0, 32'd0, 4);
    check_eq("sh_nostall_cycles", 32'(log_n), 32'd2);
    check_eq("sh_nostall_D0", 32'(d_log[0]), 32'hAB);
    check_eq("sh_nostall_D1", 32'(d_log[1]), 32'h12);
    rdy_writes = 1'b1;

    // Address faults and the top-of-space boundary.
    do_access("lw_hi", 1'b0, SZ_W, 1'b0, 32'h0001_0000, 32'd0, 0, 1'b1, 32'd0, 2);
    check_eq("lw_hi_cycles", 32'(log_n), 32'd0);
    check_eq("lw_hi_RWn", 32'(rw_at_resp), 32'd1);
    check_eq("lw_hi_oe", 32'(oe_at_resp), 32'd0);
    do_access("lw_fffe", 1'b0, SZ_W, 1'b0, 32'h0000_FFFE, 32'd0, 0, 1'b1, 32'd0, 2);
    check_eq("lw_fffe_cycles", 32'(log_n), 32'd0);
    do_access("size11", 1'b0, SZ_X, 1'b0, 32'h0000_0400, 32'd0, 0, 1'b1, 32'd0, 2);
    do_access("sw_size11", 1'b1, SZ_X, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 0, 1'b1, 32'd0, 2);
    check_eq("sw_size11_oe", 32'(oe_at_resp), 32'd0);
    do_access("lh_ffff", 1'b0, SZ_H, 1'b0, 32'h0000_FFFF, 32'd0, 0, 1'b1, 32'd0, 2);
    set_rd(16'hFFFC, 8'h01, 8'h02, 8'h03, 8'h04);
    do_access("lw_fffc", 1'b0, SZ_W, 1'b0, 32'h0000_FFFC, 32'd0, 0, 1'b0, 32'h0403_0201, 6);
    check_eq("lw_fffc_A3", 32'(a_log[3]), 32'hFFFF);
    set_rd(16'hFFFF, 8'h5A, 8'h00, 8'h00, 8'h00);
    do_access("lb_ffff", 1'b0, SZ_B, 1'b0, 32'h0000_FFFF, 32'd0, 0, 1'b0, 32'h0000_005A, 3);

    // Misaligned word.
    set_rd(16'h0101, 8'h11, 8'h22, 8'h33, 8'h44);
`ifdef RV32_MISALIGN_TRAP_EN
    do_access("lw_mis", 1'b0, SZ_W, 1'b0, 32'h0000_0101, 32'd0, 0, 1'b1, 32'd0, 2);
    check_eq("lw_mis_cycles", 32'(log_n), 32'd0);
`else
    do_access("lw_mis", 1'b0, SZ_W, 1'b0, 32'h0000_0101, 32'd0, 0, 1'b0, 32'h4433_2211, 6);
    check_eq("lw_mis_cycles", 32'(log_n), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("lw_mis_A%0d", i), 32'(a_log[i]), 32'h0101 + 32'(i));
`endif

    // Reset in the middle of a word load, after byte 1 has completed.
    set_rd(16'h2000, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    seen_resp = 1'b0;
    @(posedge PH0IN);
    check_eq("rstmid_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = SZ_W;
    req_addr  = 32'h0000_2000;
    @(posedge PH0IN);
    req_valid = 1'b0;
    seen_resp = seen_resp | resp_valid;
    D_i = bus_byte(A_o);
    @(posedge PH0IN);
    seen_resp = seen_resp | resp_valid;
    D_i = bus_byte(A_o);
    @(posedge PH0IN);
    seen_resp = seen_resp | resp_valid;
    check_eq("rstmid_A2", 32'(A_o), 32'h2002);
    rst_n = 1'b0;
    @(posedge PH0IN);
    seen_resp = seen_resp | resp_valid;
    check_eq("rstmid_RWn", 32'(RWn), 32'd1);
    check_eq("rstmid_D_oe", 32'(D_oe), 32'd0);
    check_eq("rstmid_MLn", 32'(MLn), 32'd1);
    check_eq("rstmid_A", 32'(A_o), 32'd0);
    @(posedge PH0IN);
    check_eq("rstmid_ready_low", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge PH0IN);
      seen_resp = seen_resp | resp_valid;
    end
    check_eq("rstmid_no_resp", 32'(seen_resp), 32'd0);
    $display("reset mid-word: resp seen=%0d", seen_resp);
    set_rd(16'h0042, 8'h7F, 8'h00, 8'h00, 8'h00);
    do_access("lb_after_rst", 1'b0, SZ_B, 1'b0, 32'h0000_0042, 32'd0, 0, 1'b0, 32'h0000_007F, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
